instr_fetch_ctrl: RTL and testbench
===================================

// Module: instr_fetch_ctrl
// PURPOSE
//  Fetch-side responder to the program counter register. Takes the current PC,
//  runs a req/ack transaction on the instruction memory port, and presents the
//  returned instruction to the IF/ID stage.
//  Drives busy_o back to the PC register, so the PC advances exactly once per
//  delivered instruction. Also handles flush, misaligned PC, bus error and ack timeout.
// PARAMETERS
//  XLEN          32            address/data width
//  NOP_INSTR     32'h00000013  instruction driven when nothing valid (addi x0,x0,0)
//  TIMEOUT_CYC   256           max FETCH cycles without ack before timeout fault
//  TMO_W         8             timeout counter width, $clog2(TIMEOUT_CYC)
// PORTS
//  clk_i         in   1     clock, rising edge
//  rst_ni        in   1     asynchronous reset, active low
//  pc_i          in   XLEN  current PC from PC register
//  stall_i       in   1     downstream stall (hazard unit)
//  flush_i       in   1     redirect (branch/jump taken), discard in-flight fetch
//  busy_o        out  1     to PC register: 1 = hold PC
//  instr_o       out  XLEN  fetched instruction
//  instr_pc_o    out  XLEN  address of instr_o
//  instr_valid_o out  1     instr_o/instr_pc_o/fault_o valid
//  fault_o       out  2     00 none, 01 misaligned, 10 bus error, 11 timeout
//  mem_req_o     out  1     memory request, level, held until ack
//  mem_addr_o    out  XLEN  word-aligned fetch address, stable while mem_req_o
//  mem_ack_i     in   1     one-cycle ack, rdata/err valid same cycle
//  mem_rdata_i   in   XLEN  read data
//  mem_err_i     in   1     bus error, qualified by mem_ack_i
// BEHAVIOUR
//  Reset (async, rst_ni=0): state IDLE; mem_req_o=0, mem_addr_o=0, instr_o=NOP_INSTR,
//   instr_pc_o=0, instr_valid_o=0, fault_o=00, busy_o=1, timeout count=0.
//   Reset asserted mid-transaction drops mem_req_o immediately; no ack is awaited.
//  All outputs registered except busy_o (decoded from state, stall_i, flush_i).
//  busy_o=0 only when state==DELIVER && !stall_i && !flush_i; otherwise 1.
//  States:
//   IDLE:    if stall_i or flush_i, stay.
//            elif pc_i[1:0]!=0: load instr_q=NOP_INSTR, fault=01, pc_q=pc_i -> DELIVER.
//            else mem_addr_o<=pc_i, pc_q<=pc_i, mem_req_o<=1, count<=0 -> FETCH.
//   FETCH:   count++ each cycle.
//            ack&&flush_i: discard -> IDLE. flush_i without ack -> DROP.
//            ack&&!err: instr_q=rdata, fault=00 -> DELIVER.
//            ack&&err: instr_q=NOP, fault=10 -> DELIVER.
//            count==TIMEOUT_CYC-1 without ack: instr_q=NOP, fault=11 -> DELIVER.
//            mem_req_o cleared on leaving FETCH.
//   DROP:    mem_req_o held; on ack, or on timeout: req low -> IDLE. Nothing delivered.
//   DELIVER: instr_valid_o=1 with instr_q/pc_q/fault.
//            flush_i: valid low -> IDLE.
//            stall_i: hold, outputs unchanged.
//            else: one cycle, busy_o=0 so PC updates at this edge -> IDLE.
//  Rules:
//   - Memory must accept req deassertion as abort after a timeout.
//   - Acks seen in IDLE/DELIVER are ignored.
//   - Throughput: 1 instr per (ack latency + 2) cycles; 1-cycle ack -> 3 cycles.
//   - Exactly one busy_o=0 cycle per instruction leaving DELIVER; never during reset.
//   - flush_i has priority over stall_i; stall_i has priority over ack delivery.
//     An ack received while stall_i is high is still captured, then held in DELIVER.
//   - count saturates; no wrap. Address arithmetic not performed here; PC reg owns PC+4.
// STRUCTURE
//  Shared package (cpu_pkg): fetch state enum (IDLE/FETCH/DROP/DELIVER),
//   FAULT_* 2-bit codes, NOP_INSTR constant, XLEN.
//  Single module; no sub-module needed (FSM + timeout counter + output regs).
// TESTING
//  1 Reset release, PC=0, ack latency 1, rdata 32'h00500093 -> req at addr 0;
//    valid with instr 00500093, fault 00, busy_o=0 for exactly 1 cycle.
//  2 stall_i high 3 cycles during DELIVER -> valid and instr held 3 cycles,
//    busy_o=1 throughout, then one busy_o=0 cycle.
//  3 flush_i in FETCH (ack latency 4), pc_i->0x100 -> DROP, no valid;
//    next req addr 0x100.
//  4 pc_i=0x102 -> no mem_req_o; valid with fault 01, instr 00000013, instr_pc 0x102.
//  5 No ack for 256 cycles -> req drops; valid with fault 11.
//    mem_err_i with ack -> fault 10.
//  6 rst_ni low mid-FETCH -> mem_req_o=0 and busy_o=1 without clock edge;
//    after release, fetch restarts at 0.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared fetch-side types and constants: state encoding, fault codes,
// datapath width and the filler instruction used when nothing valid was fetched.
package instr_fetch_ctrl_pkg;

    localparam int XLEN = 32;

    // addi x0,x0,0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DROP,
        S_DELIVER
    } fetch_state_e;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_BUS      = 2'b10,
        FAULT_TIMEOUT  = 2'b11
    } fault_e;

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Instruction memory req/ack port. The fetch controller is the master;
// the memory (or a bench model of it) is the slave.
interface instr_fetch_ctrl_if;
    import instr_fetch_ctrl_pkg::*;

    logic            mem_req_o;
    logic [XLEN-1:0] mem_addr_o;
    logic            mem_ack_i;
    logic [XLEN-1:0] mem_rdata_i;
    logic            mem_err_i;

    modport master (
        output mem_req_o,
        output mem_addr_o,
        input  mem_ack_i,
        input  mem_rdata_i,
        input  mem_err_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_addr_o,
        output mem_ack_i,
        output mem_rdata_i,
        output mem_err_i
    );

endinterface

// File: rtl/instr_fetch_ctrl.sv
// Fetch controller: turns the current PC into one memory transaction and hands
// the result to IF/ID, holding the PC register via busy_o until delivery.
module instr_fetch_ctrl
    import instr_fetch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 256,
    parameter int TMO_W       = $clog2(TIMEOUT_CYC)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [XLEN-1:0]    pc_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output logic               busy_o,
    output logic [XLEN-1:0]    instr_o,
    output logic [XLEN-1:0]    instr_pc_o,
    output logic               instr_valid_o,
    output logic [1:0]         fault_o,
    instr_fetch_ctrl_if.master mem
);

    fetch_state_e    state_q, state_d;
    fault_e          fault_q, fault_d;
    logic            req_d, valid_d;
    logic [XLEN-1:0] addr_d, instr_d, pc_d;
    logic [TMO_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic            timeout;

    // The counter sticks at its maximum so a long DROP can never wrap back into range.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + TMO_W'(1);
    assign timeout = (cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign fault_o = fault_q;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d = state_q;
        fault_d = fault_q;
        req_d   = mem.mem_req_o;
        addr_d  = mem.mem_addr_o;
        instr_d = instr_o;
        pc_d    = instr_pc_o;
        valid_d = instr_valid_o;
        cnt_d   = cnt_q;
        busy_o  = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (!stall_i && !flush_i) begin
                    pc_d = pc_i;
                    if (pc_i[1:0] != 2'b00) begin
                        instr_d = NOP_INSTR;
                        fault_d = FAULT_MISALIGN;
                        valid_d = 1'b1;
                        state_d = S_DELIVER;
                    end else begin
                        addr_d  = pc_i;
                        req_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                cnt_d = cnt_inc;
                if (flush_i) begin
                    // Without the ack in hand the request must stay up until memory answers.
                    if (mem.mem_ack_i) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DROP;
                    end
                end else if (mem.mem_ack_i) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    state_d = S_DELIVER;
                    if (mem.mem_err_i) begin
                        instr_d = NOP_INSTR;
                        fault_d = FAULT_BUS;
                    end else begin
                        instr_d = mem.mem_rdata_i;
                        fault_d = FAULT_NONE;
                    end
                end else if (timeout) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    instr_d = NOP_INSTR;
                    fault_d = FAULT_TIMEOUT;
                    state_d = S_DELIVER;
                end
            end
            S_DROP: begin
                cnt_d = cnt_inc;
                if (mem.mem_ack_i || timeout) begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_DELIVER: begin
                if (flush_i) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end else if (!stall_i) begin
                    busy_o  = 1'b0;
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            fault_q        <= FAULT_NONE;
            mem.mem_req_o  <= 1'b0;
            mem.mem_addr_o <= '0;
            instr_o        <= NOP_INSTR;
            instr_pc_o     <= '0;
            instr_valid_o  <= 1'b0;
            cnt_q          <= '0;
        end else begin
            state_q        <= state_d;
            fault_q        <= fault_d;
            mem.mem_req_o  <= req_d;
            mem.mem_addr_o <= addr_d;
            instr_o        <= instr_d;
            instr_pc_o     <= pc_d;
            instr_valid_o  <= valid_d;
            cnt_q          <= cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench for instr_fetch_ctrl: a transaction-level model checked every
// cycle, plus literal expectations on what each scenario must deliver.
module tb_instr_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        busy, valid;
    logic [31:0] instr, instr_pc;
    logic [1:0]  fault;

    instr_fetch_ctrl_if mem_if ();

    instr_fetch_ctrl dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pc_i          (pc),
        .stall_i       (stall),
        .flush_i       (flush),
        .busy_o        (busy),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (valid),
        .fault_o       (fault),
        .mem           (mem_if.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory responder settings: ack on the lat-th request cycle (0 = never).
    int          lat = 1;
    int          rc = 0;
    bit          err_mode = 1'b0;
    logic [31:0] rdata = '0;

    initial begin
        mem_if.mem_ack_i   = 1'b0;
        mem_if.mem_err_i   = 1'b0;
        mem_if.mem_rdata_i = '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_if.mem_req_o) begin
            rc++;
            mem_if.mem_ack_i = (lat != 0) && (rc == lat);
        end else begin
            rc = 0;
            mem_if.mem_ack_i = 1'b0;
        end
        mem_if.mem_err_i   = mem_if.mem_ack_i && err_mode;
        mem_if.mem_rdata_i = rdata;
    endtask

    // Behavioural model: request outstanding / being dropped / instruction on offer.
    bit          m_req, m_drop, m_valid;
    logic [31:0] m_addr, m_instr, m_pc;
    logic [1:0]  m_fault;
    int          m_wait;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_drop = 0; m_valid = 0; m_wait = 0;
            m_addr = '0; m_instr = 32'h13; m_pc = '0; m_fault = 2'd0;
        end else if (m_valid) begin
            if (flush || !stall) m_valid = 0;
        end else if (m_req && m_drop) begin
            m_wait++;
            if (mem_if.mem_ack_i || m_wait >= 256) begin m_req = 0; m_drop = 0; end
        end else if (m_req) begin
            m_wait++;
            if (flush) begin
                if (mem_if.mem_ack_i) m_req = 0;
                else m_drop = 1;
            end else if (mem_if.mem_ack_i) begin
                m_req = 0; m_valid = 1;
                m_instr = mem_if.mem_err_i ? 32'h13 : mem_if.mem_rdata_i;
                m_fault = mem_if.mem_err_i ? 2'd2 : 2'd0;
            end else if (m_wait >= 256) begin
                m_req = 0; m_valid = 1; m_instr = 32'h13; m_fault = 2'd3;
            end
        end else if (!stall && !flush) begin
            m_pc = pc;
            if (pc[1:0] != 2'b00) begin
                m_valid = 1; m_instr = 32'h13; m_fault = 2'd1;
            end else begin
                m_req = 1; m_addr = pc; m_wait = 0;
            end
        end
    end

    typedef struct { logic [31:0] instr; logic [31:0] pc; logic [1:0] fault; } deliv_t;
    deliv_t      deliv_q[$];
    logic [31:0] req_q[$];
    int          req_hi = 0;
    int          valid_cnt = 0;
    logic        prev_req = 1'b0;

    always @(negedge clk) begin
        check("busy", busy, !(m_valid && !stall && !flush));
        check("mem_req", mem_if.mem_req_o, m_req);
        check("valid", valid, m_valid);
        if (m_req) check("mem_addr", mem_if.mem_addr_o, m_addr);
        if (m_valid) begin
            check("instr", instr, m_instr);
            check("instr_pc", instr_pc, m_pc);
            check("fault", fault, m_fault);
        end
        if (rst_n) begin
            if (!busy) deliv_q.push_back('{instr, instr_pc, fault});
            if (mem_if.mem_req_o && !prev_req) req_q.push_back(mem_if.mem_addr_o);
            if (mem_if.mem_req_o) req_hi++;
            if (valid) valid_cnt++;
        end
        prev_req = mem_if.mem_req_o;
    end

    task automatic wait_deliv(input int target, input int budget, input string name);
        int n = 0;
        while (deliv_q.size() < target && n < budget) begin tick(); n++; end
        check(name, deliv_q.size(), target);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (valid !== 1'b1 && n < budget) begin tick(); n++; end
        check(name, valid, 1'b1);
    endtask

    task automatic wait_req(input int budget, input string name);
        int n = 0;
        while (mem_if.mem_req_o !== 1'b1 && n < budget) begin tick(); n++; end
        check(name, mem_if.mem_req_o, 1'b1);
    endtask

    initial begin
        int d0, r0, h0, v0;

        // Reset state
        repeat (3) tick();
        check("rst_req", mem_if.mem_req_o, 1'b0);
        check("rst_addr", mem_if.mem_addr_o, 32'h0);
        check("rst_busy", busy, 1'b1);
        check("rst_valid", valid, 1'b0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_pc", instr_pc, 32'h0);
        check("rst_fault", fault, 2'b00);

        // 1: first fetch at PC 0, single-cycle ack
        pc = 32'h0; lat = 1; rdata = 32'h0050_0093; rst_n = 1'b1;
        wait_deliv(1, 20, "t1_deliver");
        stall = 1'b1;
        repeat (3) tick();
        check("t1_one_busy_low", deliv_q.size(), 1);
        check("t1_instr", deliv_q[0].instr, 32'h0050_0093);
        check("t1_pc", deliv_q[0].pc, 32'h0);
        check("t1_fault", deliv_q[0].fault, 2'b00);
        check("t1_req_addr", req_q[0], 32'h0);

        // 2: downstream stall while the instruction is on offer
        d0 = deliv_q.size(); v0 = valid_cnt;
        pc = 32'h4; rdata = 32'h0040_0113; stall = 1'b0;
        wait_valid(20, "t2_valid");
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        tick();
        stall = 1'b1;
        repeat (2) tick();
        check("t2_valid_cycles", valid_cnt - v0, 4);
        check("t2_busy_low", deliv_q.size() - d0, 1);
        check("t2_instr", deliv_q[d0].instr, 32'h0040_0113);

        // 3: flush during FETCH, redirect to 0x100
        d0 = deliv_q.size(); r0 = req_q.size();
        pc = 32'h8; lat = 4; rdata = 32'h00a0_0193; stall = 1'b0;
        wait_req(20, "t3_req");
        flush = 1'b1; pc = 32'h100;
        tick();
        flush = 1'b0;
        wait_deliv(d0 + 1, 40, "t3_deliver");
        stall = 1'b1;
        repeat (2) tick();
        check("t3_reqs", req_q.size() - r0, 2);
        check("t3_first_addr", req_q[r0], 32'h8);
        check("t3_redirect_addr", req_q[r0 + 1], 32'h100);
        check("t3_pc", deliv_q[d0].pc, 32'h100);
        check("t3_instr", deliv_q[d0].instr, 32'h00a0_0193);

        // 4: misaligned PC never reaches memory
        d0 = deliv_q.size(); r0 = req_q.size();
        pc = 32'h102; stall = 1'b0;
        wait_deliv(d0 + 1, 20, "t4_deliver");
        stall = 1'b1;
        repeat (2) tick();
        check("t4_no_req", req_q.size() - r0, 0);
        check("t4_fault", deliv_q[d0].fault, 2'b01);
        check("t4_instr", deliv_q[d0].instr, 32'h0000_0013);
        check("t4_pc", deliv_q[d0].pc, 32'h102);

        // 5a: no ack -> timeout after 256 request cycles
        d0 = deliv_q.size(); h0 = req_hi;
        pc = 32'h200; lat = 0; stall = 1'b0;
        wait_deliv(d0 + 1, 300, "t5_timeout_deliver");
        stall = 1'b1;
        repeat (2) tick();
        check("t5_req_cycles", req_hi - h0, 256);
        check("t5_fault", deliv_q[d0].fault, 2'b11);
        check("t5_instr", deliv_q[d0].instr, 32'h0000_0013);

        // 5b: bus error
        d0 = deliv_q.size();
        pc = 32'h204; lat = 2; err_mode = 1'b1; rdata = 32'hdead_beef; stall = 1'b0;
        wait_deliv(d0 + 1, 20, "t5_err_deliver");
        stall = 1'b1; err_mode = 1'b0;
        repeat (2) tick();
        check("t5_err_fault", deliv_q[d0].fault, 2'b10);
        check("t5_err_instr", deliv_q[d0].instr, 32'h0000_0013);

        // 5c: flush while delivering discards the instruction
        d0 = deliv_q.size();
        pc = 32'h300; lat = 1; rdata = 32'h0000_0033; stall = 1'b0;
        wait_valid(20, "t5_flush_valid");
        flush = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b1;
        repeat (2) tick();
        check("t5_flush_no_deliver", deliv_q.size() - d0, 0);
        check("t5_flush_valid_low", valid, 1'b0);

        // 6: asynchronous reset mid-FETCH
        pc = 32'h400; lat = 0; stall = 1'b0;
        wait_req(20, "t6_req");
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_req", mem_if.mem_req_o, 1'b0);
        check("t6_async_busy", busy, 1'b1);
        repeat (2) tick();
        d0 = deliv_q.size(); r0 = req_q.size();
        pc = 32'h0; lat = 1; rdata = 32'h0050_0093; rst_n = 1'b1;
        wait_deliv(d0 + 1, 20, "t6_deliver");
        check("t6_restart_addr", req_q[r0], 32'h0);
        check("t6_pc", deliv_q[d0].pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
